// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter in front of a FIFO write port.
// Optional burst lock (define ARB_BURST_LOCK_EN) holds the port for up to BURST_LEN words.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_req,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  input  logic                  i_full,
  output logic [1:0]            o_grant,
  output logic [1:0]            o_ack,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_w_data
);

  if (BURST_LEN < 2 || BURST_LEN > 15) begin : g_burst_len_check
    $error("fifo_wr_arbiter: BURST_LEN must be in 2..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   owner;
  logic   owner_req;
  logic   other_req;
  logic   xfer;
  logic   tenure_over;
  logic   owner_change;
  state_t other_state;

  // Owner index is only meaningful outside IDLE; IDLE aliases to 0 so the data mux defaults to requester 0.
  assign owner        = (state == OWN1);
  assign owner_req    = i_req[owner];
  assign other_req    = i_req[~owner];
  assign other_state  = owner ? OWN0 : OWN1;
  assign xfer         = (state != IDLE) && owner_req && !i_full;
  assign owner_change = (state_nxt != state);

`ifdef ARB_BURST_LOCK_EN
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);
  logic [3:0] burst_cnt;

  // Current transfer ends the tenure once it is the BURST_LEN-th; saturated count keeps it over.
  assign tenure_over = (burst_cnt >= BURST_MAX - 4'd1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      burst_cnt <= '0;
    end else if (owner_change) begin
      burst_cnt <= '0;
    end else if (xfer && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
`else
  assign tenure_over = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (owner_change && state_nxt != IDLE) begin
        last <= (state_nxt == OWN1);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    o_grant   = {state == OWN1, state == OWN0};
    o_wr      = xfer;
    o_ack     = xfer ? o_grant : 2'b00;
    o_w_data  = owner ? i_data_1 : i_data_0;
    unique case (state)
      IDLE: begin
        unique case (i_req)
          2'b01:   state_nxt = OWN0;
          2'b10:   state_nxt = OWN1;
          2'b11:   state_nxt = last ? OWN0 : OWN1;
          default: state_nxt = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (!owner_req) begin
          state_nxt = other_req ? other_state : IDLE;
        end else if (xfer && other_req && tenure_over) begin
          state_nxt = other_state;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an owner/tenure reference model.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int OW = 5 + DW;
`ifdef ARB_BURST_LOCK_EN
  localparam int RUN = BL;
`else
  localparam int RUN = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [DW-1:0] d0, d1;
  logic          full;
  logic [1:0]    grant, ack;
  logic          wr;
  logic [DW-1:0] wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: owner -1 = idle, last = previous owner, words = transfers in current tenure.
  int m_owner, m_last, m_words;
  logic [OW-1:0] exp;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_req   (req),
    .i_data_0(d0),
    .i_data_1(d1),
    .i_full  (full),
    .o_grant (grant),
    .o_ack   (ack),
    .o_wr    (wr),
    .o_w_data(wdata)
  );

  function automatic logic [OW-1:0] model_out();
    logic [1:0]    g;
    logic [1:0]    a;
    logic          w;
    logic [DW-1:0] wd;
    g  = 2'b00;
    a  = 2'b00;
    w  = 1'b0;
    wd = (m_owner == 1) ? d1 : d0;
    if (m_owner >= 0) begin
      g[m_owner[0]] = 1'b1;
      if (req[m_owner[0]] && !full) begin
        w = 1'b1;
        a[m_owner[0]] = 1'b1;
      end
    end
    return {g, a, w, wd};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_words = 0;
  endtask

  task automatic model_step();
    int nxt;
    int other;
    bit over;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req == 2'b11)      nxt = 1 - m_last;
      else if (req == 2'b01) nxt = 0;
      else if (req == 2'b10) nxt = 1;
    end else begin
      other = 1 - m_owner;
      if (!req[m_owner[0]]) begin
        nxt = req[other[0]] ? other : -1;
      end else if (!full) begin
        m_words++;
        over = (m_words >= RUN);
        if (over && req[other[0]]) nxt = other;
      end
    end
    if (nxt != m_owner) begin
      m_words = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_owner = nxt;
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic [1:0] r, input logic f);
    req  = r;
    full = f;
    d0   = DW'($urandom);
    d1   = DW'($urandom);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b0);
      tests_run++;
      if ({grant, ack, wr} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got grant=%b ack=%b wr=%b want 00 00 0", i, grant, ack, wr);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive(2'b11, 1'b0);
    tests_run++;
    if (grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got grant=%b want 00", grant);
    end
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(2'b11, 1'b0);
      exp = model_out();
      tests_run++;
      if ({grant, ack, wr, wdata} !== exp) begin
        tests_failed++;
        $display("FAIL alternate_model cyc%0d: got %b want %b", i, {grant, ack, wr, wdata}, exp);
      end
      tests_run++;
      if (ack !== ((((i / RUN) % 2) == 0) ? 2'b01 : 2'b10) || wr !== 1'b1) begin
        tests_failed++;
        $display("FAIL alternate_order cyc%0d: got ack=%b wr=%b", i, ack, wr);
      end
      advance();
    end
  endtask

  task automatic test_single_req();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b0);
      advance();
    end
    drive(2'b10, 1'b0);
    tests_run++;
    if (grant !== 2'b00 || wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: got grant=%b wr=%b want 00 0", grant, wr);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b0);
      tests_run++;
      if (grant !== 2'b10 || ack !== 2'b10 || wr !== 1'b1 || wdata !== d1) begin
        tests_failed++;
        $display("FAIL single_word%0d: got grant=%b ack=%b wr=%b data=%h want 10 10 1 %h",
                 i, grant, ack, wr, wdata, d1);
      end
      advance();
    end
    drive(2'b00, 1'b0);
    tests_run++;
    if (grant !== 2'b10 || wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drop: got grant=%b wr=%b want 10 0", grant, wr);
    end
    advance();
    drive(2'b00, 1'b0);
    tests_run++;
    if (grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_idle_after: got grant=%b want 00", grant);
    end
    advance();
  endtask

  task automatic test_full_stall();
    drive(2'b01, 1'b0);
    advance();
    drive(2'b01, 1'b0);
    tests_run++;
    if (ack !== 2'b01 || wdata !== d0) begin
      tests_failed++;
      $display("FAIL stall_pre: got ack=%b data=%h want 01 %h", ack, wdata, d0);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 1'b1);
      tests_run++;
      if (grant !== 2'b01 || wr !== 1'b0 || ack !== 2'b00) begin
        tests_failed++;
        $display("FAIL stall_full%0d: got grant=%b wr=%b ack=%b want 01 0 00", i, grant, wr, ack);
      end
      advance();
    end
    drive(2'b11, 1'b0);
    tests_run++;
    if (ack !== 2'b01 || wr !== 1'b1 || wdata !== d0) begin
      tests_failed++;
      $display("FAIL stall_resume: got ack=%b wr=%b data=%h want 01 1 %h", ack, wr, wdata, d0);
    end
    advance();
  endtask

  task automatic test_solo_run();
    int writes;
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0);
      advance();
    end
    drive(2'b01, 1'b0);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b0);
      if (wr === 1'b1 && ack === 2'b01) writes++;
      advance();
    end
    tests_run++;
    if (writes != 6) begin
      tests_failed++;
      $display("FAIL solo_run: got %0d back-to-back writes want 6", writes);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b0);
      advance();
    end
    drive(2'b11, 1'b0);
    advance();
    drive(2'b11, 1'b0);
    tests_run++;
    if (grant !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_own1: got grant=%b want 10", grant);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (grant !== 2'b00 || wr !== 1'b0 || ack !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got grant=%b wr=%b ack=%b want 00 0 00", grant, wr, ack);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(2'b11, 1'b0);
    advance();
    drive(2'b11, 1'b0);
    tests_run++;
    if (grant !== 2'b01 || ack !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_regrant: got grant=%b ack=%b want 01 01", grant, ack);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), ($urandom_range(0, 3) == 0));
      exp = model_out();
      tests_run++;
      if ({grant, ack, wr, wdata} !== exp) begin
        tests_failed++;
        $display("FAIL random_model cyc%0d: req=%b full=%b got %b want %b",
                 i, req, full, {grant, ack, wr, wdata}, exp);
      end
      tests_run++;
      if (!$onehot0(grant) || !$onehot0(ack) || (wr && full)) begin
        tests_failed++;
        $display("FAIL random_invariant cyc%0d: got grant=%b ack=%b wr=%b full=%b", i, grant, ack, wr, full);
      end
      advance();
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b00;
    full = 1'b0;
    d0   = '0;
    d1   = '0;
    model_reset();
    #1;
    test_reset();
    test_single_req();
    test_full_stall();
    test_solo_run();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
